// File: rtl/ysyx_ifu_sram_resp_pkg.sv
// rtl/ysyx_ifu_sram_resp_pkg.sv - FSM encodings and constants for ysyx_ifu_sram_resp (YSYX_SRAM_RAND_DELAY_EN adds LFSR delay)
`ifndef ysyx_SRAM_IDLE
`define ysyx_SRAM_IDLE 2'd0
`endif
`ifndef ysyx_SRAM_WAIT
`define ysyx_SRAM_WAIT 2'd1
`endif
`ifndef ysyx_SRAM_RESP
`define ysyx_SRAM_RESP 2'd2
`endif
`ifndef ysyx_SRAM_BASE
`define ysyx_SRAM_BASE 32'h8000_0000
`endif

package ysyx_ifu_sram_resp_pkg;

    typedef logic [1:0] sram_state_t;

    localparam sram_state_t ST_IDLE   = `ysyx_SRAM_IDLE;
    localparam sram_state_t ST_WAIT   = `ysyx_SRAM_WAIT;
    localparam sram_state_t ST_RESP   = `ysyx_SRAM_RESP;

    localparam logic [31:0] SRAM_BASE = `ysyx_SRAM_BASE;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

endpackage

// File: rtl/ysyx_ifu_sram_resp_lfsr8.sv
// rtl/ysyx_ifu_sram_resp_lfsr8.sv - 8-bit Fibonacci LFSR, only built with YSYX_SRAM_RAND_DELAY_EN
`ifdef YSYX_SRAM_RAND_DELAY_EN
module ysyx_lfsr8
    import ysyx_ifu_sram_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);

    // x^8 + x^6 + x^5 + x^4 + 1
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

endmodule
`endif

// File: rtl/ysyx_macro.v
// rtl/ysyx_macro.v - state encodings and base address shared by the IFU SRAM responder
`ifndef ysyx_SRAM_IDLE
`define ysyx_SRAM_IDLE 2'd0
`endif
`ifndef ysyx_SRAM_WAIT
`define ysyx_SRAM_WAIT 2'd1
`endif
`ifndef ysyx_SRAM_RESP
`define ysyx_SRAM_RESP 2'd2
`endif
`ifndef ysyx_SRAM_BASE
`define ysyx_SRAM_BASE 32'h8000_0000
`endif

// File: rtl/ysyx_ifu_sram_resp.sv
// rtl/ysyx_ifu_sram_resp.sv - IFU fetch responder over a word SRAM; YSYX_SRAM_RAND_DELAY_EN adds 0-3 random wait cycles
module ysyx_ifu_sram_resp
    import ysyx_ifu_sram_resp_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 1024,
    parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(SRAM_BASE),
    parameter int                LATENCY = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_rvalid_o,
    output logic              ifu_rerr_o,
    output logic              busy_o,
    input  logic              ld_wen,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0] ld_wdata
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam int                CNT_W = $clog2(LATENCY + 4);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

    sram_state_t       state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_load;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic [ADDR_W-1:0] rd_addr, rd_off, wr_off;
    logic              rd_hit, wr_hit;
    logic [IDX_W-1:0]  rd_idx, wr_idx;

`ifdef YSYX_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    ysyx_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr_q)
    );

    assign cnt_load = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
    assign cnt_load = CNT_W'(LATENCY);
`endif

    // A zero-latency accept samples the array on the accepting edge, before addr_q holds it.
    always_comb begin
        rd_addr = (state == ST_IDLE) ? ifu_araddr : addr_q;
        rd_off  = rd_addr - BASE;
        rd_hit  = rd_off < SPAN;
        rd_idx  = rd_off[IDX_W+1:2];
        wr_off  = ld_waddr - BASE;
        wr_hit  = wr_off < SPAN;
        wr_idx  = wr_off[IDX_W+1:2];
    end

    assign accept     = (state == ST_IDLE) && ifu_arvalid;
    assign enter_resp = (state_n == ST_RESP) && (state != ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q <= ifu_araddr;
                cnt    <= cnt_load;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (enter_resp) begin
                rdata_q <= rd_hit ? mem[rd_idx] : '0;
                err_q   <= ~rd_hit;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (ifu_arvalid) begin
                    state_n = (cnt_load == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        ifu_rvalid_o = (state == ST_RESP);
        ifu_rerr_o   = (state == ST_RESP) && err_q;
        busy_o       = (state != ST_IDLE);
        ifu_rdata_o  = rdata_q;
    end

    // The array is not reset; the loader may write in any state.
    always_ff @(posedge clk) begin
        if (ld_wen && wr_hit) begin
            mem[wr_idx] <= ld_wdata;
        end
    end

endmodule

// File: tb/tb_ysyx_ifu_sram_resp.sv
// tb/tb_ysyx_ifu_sram_resp.sv - bench for ysyx_ifu_sram_resp at LATENCY 2 and 0
module tb_ysyx_ifu_sram_resp;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             ld_wen;
    logic [31:0]      ld_waddr, ld_wdata;
    logic [1:0]       arvalid;
    logic [1:0][31:0] araddr;
    logic [1:0][31:0] rdata;
    logic [1:0]       rvalid, rerr, busy;

    int total = 0;
    int bad   = 0;
    logic started = 1'b0;

    ysyx_ifu_sram_resp #(.LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst),
        .ifu_araddr(araddr[0]), .ifu_arvalid(arvalid[0]),
        .ifu_rdata_o(rdata[0]), .ifu_rvalid_o(rvalid[0]), .ifu_rerr_o(rerr[0]), .busy_o(busy[0]),
        .ld_wen(ld_wen), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata)
    );

    ysyx_ifu_sram_resp #(.LATENCY(0)) dut_l0 (
        .clk(clk), .rst(rst),
        .ifu_araddr(araddr[1]), .ifu_arvalid(arvalid[1]),
        .ifu_rdata_o(rdata[1]), .ifu_rvalid_o(rvalid[1]), .ifu_rerr_o(rerr[1]), .busy_o(busy[1]),
        .ld_wen(ld_wen), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata)
    );

    // Model: a request accepted at edge e is answered from the array as it stands before edge e+LAT.
    logic [31:0]      mmem [1024];
    logic [1:0]       m_pend, m_resp, m_err;
    logic [1:0][31:0] m_addr, m_last;
    int               m_at [2];
    int               cyc = 0;
    logic [31:0]      off;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k] = 1'b0;
                m_resp[k] = 1'b0;
                m_last[k] = 32'h0;
            end else begin
                if (!m_pend[k] && !m_resp[k] && arvalid[k]) begin
                    m_pend[k] = 1'b1;
                    m_addr[k] = araddr[k];
                    m_at[k]   = cyc + lat_of(k);
                end
                m_resp[k] = 1'b0;
                if (m_pend[k] && cyc == m_at[k]) begin
                    m_pend[k] = 1'b0;
                    m_resp[k] = 1'b1;
                    off = m_addr[k] - BASE;
                    if (off < 32'd4096) begin
                        m_last[k] = mmem[off[11:2]];
                        m_err[k]  = 1'b0;
                    end else begin
                        m_last[k] = 32'h0;
                        m_err[k]  = 1'b1;
                    end
                end
            end
        end
        if (ld_wen) begin
            off = ld_waddr - BASE;
            if (off < 32'd4096) mmem[off[11:2]] = ld_wdata;
        end
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'(m_resp[k]));
                chk($sformatf("rerr%0d", k), 32'(rerr[k]), 32'(m_resp[k] & m_err[k]));
                chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_pend[k] | m_resp[k]));
                chk($sformatf("rdata%0d", k), rdata[k], m_last[k]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_wen = 1'b1; ld_waddr = a; ld_wdata = d;
        step();
        ld_wen = 1'b0;
    endtask

    task automatic fetch(input int k, input logic [31:0] a, output logic [31:0] d, output logic e);
        logic got;
        got = 1'b0; d = 32'h0; e = 1'b0;
        araddr[k] = a; arvalid[k] = 1'b1;
        step();
        arvalid[k] = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (rvalid[k]) begin
                got = 1'b1; d = rdata[k]; e = rerr[k];
            end
            step();
        end
        chk($sformatf("resp_seen%0d", k), 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          cnt;

        rst = 1'b1; ld_wen = 1'b0; ld_waddr = '0; ld_wdata = '0;
        arvalid = '0; araddr = '0;
        step(); step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
            chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst_rerr%0d", k), 32'(rerr[k]), 32'd0);
            chk($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
        end
        araddr[0] = BASE; arvalid[0] = 1'b1;
        step();
        rst = 1'b0; arvalid[0] = 1'b0; started = 1'b1;
        @(negedge clk);
        chk("rst_beats_arvalid", 32'(busy[0]), 32'd0);

        load(BASE,              32'h0000_0413);
        load(BASE + 32'h4,      32'h00A0_0093);
        load(BASE + 32'h8,      32'h0010_0113);
        load(BASE + 32'hFFC,    32'hDEAD_BEEF);
        load(32'h8000_1000,     32'hFFFF_FFFF);
        load(32'h7FFF_FFFC,     32'h1234_5678);

        araddr[0] = BASE; araddr[1] = BASE; arvalid = 2'b11;
        step();
        arvalid = 2'b00;
        @(negedge clk);
        chk("l2_T1_rvalid", 32'(rvalid[0]), 32'd0);
        chk("l0_T1_rvalid", 32'(rvalid[1]), 32'd1);
        chk("l0_T1_rdata", rdata[1], 32'h0000_0413);
        step(); @(negedge clk);
        chk("l2_T2_rvalid", 32'(rvalid[0]), 32'd0);
        step(); @(negedge clk);
        chk("l2_T3_rvalid", 32'(rvalid[0]), 32'd1);
        chk("l2_T3_rdata", rdata[0], 32'h0000_0413);
        chk("l2_T3_rerr", 32'(rerr[0]), 32'd0);
        step(); @(negedge clk);
        chk("l2_T4_rvalid", 32'(rvalid[0]), 32'd0);
        chk("l2_T4_busy", 32'(busy[0]), 32'd0);

        araddr[1] = BASE + 32'h4; arvalid[1] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(); @(negedge clk);
            cnt += int'(rvalid[1]);
        end
        arvalid[1] = 1'b0;
        chk("l0_pulses_in_8", 32'(cnt), 32'd4);
        step();

        fetch(0, 32'h7FFF_FFFC, d, e);
        chk("oor_low_rdata", d, 32'h0);
        chk("oor_low_rerr", 32'(e), 32'd1);
        fetch(0, 32'h8000_1000, d, e);
        chk("oor_high_rdata", d, 32'h0);
        chk("oor_high_rerr", 32'(e), 32'd1);
        fetch(1, 32'h8000_1000, d, e);
        chk("oor_l0_rerr", 32'(e), 32'd1);

        araddr[0] = BASE + 32'h4; arvalid[0] = 1'b1;
        step();
        araddr[0] = BASE + 32'h8;
        step();
        arvalid[0] = 1'b0;
        step(); @(negedge clk);
        chk("held_rvalid", 32'(rvalid[0]), 32'd1);
        chk("held_rdata", rdata[0], 32'h00A0_0093);
        step();
        fetch(0, BASE + 32'h6, d, e);
        chk("lowbits_rdata", d, 32'h00A0_0093);

        araddr[0] = BASE + 32'h8; arvalid[0] = 1'b1;
        step();
        arvalid[0] = 1'b0;
        step();
        ld_wen = 1'b1; ld_waddr = BASE + 32'h8; ld_wdata = 32'hCAFE_0137;
        step();
        ld_wen = 1'b0;
        @(negedge clk);
        chk("race_rvalid", 32'(rvalid[0]), 32'd1);
        chk("race_old_data", rdata[0], 32'h0010_0113);
        step();
        fetch(0, BASE + 32'h8, d, e);
        chk("race_new_data", d, 32'hCAFE_0137);

        araddr[0] = BASE; arvalid[0] = 1'b1;
        step();
        arvalid[0] = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(); @(negedge clk);
            cnt += int'(rvalid[0]);
        end
        chk("midrst_no_resp", 32'(cnt), 32'd0);
        step();
        fetch(0, BASE + 32'hFFC, d, e);
        chk("last_word_l2", d, 32'hDEAD_BEEF);
        chk("last_word_rerr", 32'(e), 32'd0);
        fetch(1, BASE + 32'hFFC, d, e);
        chk("last_word_l0", d, 32'hDEAD_BEEF);
        fetch(1, BASE, d, e);
        chk("word0_kept", d, 32'h0000_0413);

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
